// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: shares one synchronous-read ROM among NUM_REQ requesters.
// One read in flight at a time; a grant pulses gnt, drives rom_en/rom_add for
// one cycle, and the returned byte appears on rd_data with a one-hot rd_valid
// pulse two cycles after the grant.
// Arbitration is round-robin by default. Defining ROM_ARB_FIXED_PRIO_EN selects
// fixed priority (lowest set req index wins) and removes the rotation pointer.
module rom_read_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_add,
  input  logic [DATA_W-1:0]         rom_data
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  logic [NUM_REQ-1:0] gnt_d;
  logic [NUM_REQ-1:0] rd_valid_d;
  logic [DATA_W-1:0]  rd_data_d;
  logic               rom_en_d;
  logic [ADDR_W-1:0]  rom_add_d;

`ifndef ROM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  int unsigned        cand;
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Unpack the flat address bus into one entry per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

`ifdef ROM_ARB_FIXED_PRIO_EN
  // Winner select: lowest-indexed active request.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!sel_found && req[IDX_W'(i)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`else
  // Winner select: first active request at or after rr_ptr, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr_q + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!sel_found && req[IDX_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end
`endif

  // Next-state and next-output logic; pulses default low, held values default to hold.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    gnt_d      = '0;
    rd_valid_d = '0;
    rd_data_d  = rd_data;
    rom_en_d   = 1'b0;
    rom_add_d  = rom_add;
`ifndef ROM_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d     = onehot(sel_idx);
          rom_en_d  = 1'b1;
          rom_add_d = addr_arr[sel_idx];
          win_d     = sel_idx;
          state_d   = READ;
        end
      end
      READ: begin
        state_d = CAPT;
      end
      CAPT: begin
        rd_data_d  = rom_data;
        rd_valid_d = onehot(win_q);
`ifndef ROM_ARB_FIXED_PRIO_EN
        if (win_q == IDX_W'(NUM_REQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = win_q + 1'b1;
        end
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= '0;
      gnt      <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      rom_en   <= 1'b0;
      rom_add  <= '0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      gnt      <= gnt_d;
      rd_valid <= rd_valid_d;
      rd_data  <= rd_data_d;
      rom_en   <= rom_en_d;
      rom_add  <= rom_add_d;
`ifndef ROM_ARB_FIXED_PRIO_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);

endmodule
